// File: rtl/vslc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vslc_pkg
// Description : Shared types and constants for the PLC scan controller.
//               Holds the scan FSM state encoding, the default watchdog
//               limit and the data/address widths.
// Revision    : 1.0 - initial release
// ============================================================================
package vslc_pkg;

  localparam int unsigned c_DATA_W            = 8;
  localparam int unsigned c_ADDR_W            = 8;
  localparam int unsigned c_WDT_LIMIT_DEFAULT = 16;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LATCH_IN  = 3'd1,
    ST_EXEC      = 3'd2,
    ST_LATCH_OUT = 3'd3,
    ST_WAIT      = 3'd4,
    ST_FAULT     = 3'd5
  } state_t;

endpackage
`default_nettype wire

// File: rtl/vslc_scan_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : vslc_scan_ctrl_if
// Description : Step handshake between the scan controller and the PLC core.
//   step_req    : controller asks the core to execute the instruction at pc
//   step_ack    : core has completed the instruction at pc
//   pc          : current program address
//   addr_strobe : one-cycle pulse when a new pc is first presented
//   core_out    : core's live output image
//   master modport = controller side, slave modport = core side.
// Revision    : 1.0 - initial release
// ============================================================================
interface vslc_scan_ctrl_if;
  import vslc_pkg::*;

  logic                step_req;
  logic                step_ack;
  logic [c_ADDR_W-1:0] pc;
  logic                addr_strobe;
  logic [c_DATA_W-1:0] core_out;

  modport master (
    output step_req,
    output pc,
    output addr_strobe,
    input  step_ack,
    input  core_out
  );

  modport slave (
    input  step_req,
    input  pc,
    input  addr_strobe,
    output step_ack,
    output core_out
  );

endinterface
`default_nettype wire

// File: rtl/vslc_step_wdt.sv
`default_nettype none
// ============================================================================
// Module      : vslc_step_wdt
// Description : Loadable down-counter with terminal flag. Serves both as the
//               per-step watchdog and as the inter-scan WAIT countdown.
//   clk, rst_n : clock, asynchronous active-low reset
//   ena        : clock enable, counter holds when low
//   load       : load load_val (takes priority over dec)
//   load_val   : value to load
//   dec        : decrement by one, saturating at zero
//   term       : counter is zero
// Revision    : 1.0 - initial release
// ============================================================================
module vslc_step_wdt
  import vslc_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ena,
  input  logic                load,
  input  logic [c_DATA_W-1:0] load_val,
  input  logic                dec,
  output logic                term
);

  logic [c_DATA_W-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (ena) begin
      if (load) begin
        r_count <= load_val;
      end else if (dec && (r_count != '0)) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

  assign term = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/vslc_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : vslc_scan_ctrl
// Description : PLC scan-cycle controller. Each scan latches the input
//               image, steps the core through prog_len instructions, latches
//               the output image and optionally idles scan_div cycles.
//               A per-step watchdog traps a stuck core in FAULT.
//   clk, rst_n : clock, asynchronous active-low reset
//   ena        : clock enable for every register
//   run        : continuous scan request (level)
//   prog_len   : instructions per scan (sampled at scan start)
//   scan_div   : idle cycles between scans (sampled at scan start)
//   in_pins    : raw inputs
//   core       : step handshake to the core (master side)
//   in_img     : input image frozen for the scan
//   out_img    : output image published at end of scan
//   scan_busy  : controller is neither IDLE nor FAULT
//   fault      : watchdog trap active
//   scan_cnt   : completed-scan counter (wraps)
// Revision    : 1.0 - initial release
// ============================================================================
module vslc_scan_ctrl
  import vslc_pkg::*;
#(
  parameter int unsigned WDT_LIMIT = c_WDT_LIMIT_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ena,
  input  logic                  run,
  input  logic [c_DATA_W-1:0]   prog_len,
  input  logic [c_DATA_W-1:0]   scan_div,
  input  logic [c_DATA_W-1:0]   in_pins,
  vslc_scan_ctrl_if.master      core,
  output logic [c_DATA_W-1:0]   in_img,
  output logic [c_DATA_W-1:0]   out_img,
  output logic                  scan_busy,
  output logic                  fault,
  output logic [c_DATA_W-1:0]   scan_cnt
);

  // Watchdog counts down from WDT_LIMIT-1; reaching zero without an ack
  // means WDT_LIMIT EXEC cycles have elapsed on the same step.
  localparam logic [c_DATA_W-1:0] c_WDT_LOAD = 8'(WDT_LIMIT - 1);

  state_t              r_state;
  state_t              w_next;
  logic [c_ADDR_W-1:0] r_pc;
  logic [c_DATA_W-1:0] r_in_img;
  logic [c_DATA_W-1:0] r_out_img;
  logic [c_DATA_W-1:0] r_scan_cnt;
  logic [c_DATA_W-1:0] r_prog_len;
  logic [c_DATA_W-1:0] r_scan_div;
  logic                r_strobe;

  logic                w_strobe_next;
  logic                w_wdt_load;
  logic                w_wdt_dec;
  logic                w_wdt_term;
  logic                w_wait_load;
  logic                w_wait_dec;
  logic                w_wait_term;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else if (ena) begin
      r_state <= w_next;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and counter control
  // --------------------------------------------------------------------------
  always_comb begin
    w_next        = r_state;
    w_wdt_load    = 1'b0;
    w_wdt_dec     = 1'b0;
    w_wait_load   = 1'b0;
    w_wait_dec    = 1'b0;
    w_strobe_next = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (run) w_next = ST_LATCH_IN;
      end

      // prog_len is live here: it is the value being sampled this cycle.
      ST_LATCH_IN: begin
        if (prog_len != '0) begin
          w_next     = ST_EXEC;
          w_wdt_load = 1'b1;
        end else begin
          w_next = ST_LATCH_OUT;
        end
      end

      ST_EXEC: begin
        if (core.step_ack) begin
          w_wdt_load = 1'b1;
          if (r_pc == r_prog_len - 8'd1) w_next = ST_LATCH_OUT;
        end else if (w_wdt_term) begin
          w_next = ST_FAULT;
        end else begin
          w_wdt_dec = 1'b1;
        end
      end

      ST_LATCH_OUT: begin
        if (r_scan_div != '0) begin
          w_next      = ST_WAIT;
          w_wait_load = 1'b1;
        end else if (run) begin
          w_next = ST_LATCH_IN;
        end else begin
          w_next = ST_IDLE;
        end
      end

      // Loaded with scan_div-1, so the state spans exactly scan_div cycles.
      ST_WAIT: begin
        if (w_wait_term) begin
          w_next = run ? ST_LATCH_IN : ST_IDLE;
        end else begin
          w_wait_dec = 1'b1;
        end
      end

      ST_FAULT: begin
        if (!run) w_next = ST_IDLE;
      end

      default: w_next = ST_IDLE;
    endcase

    // Strobe on the first cycle of EXEC and on the cycle after each ack
    // that keeps us in EXEC (i.e. a new pc is presented).
    w_strobe_next = (w_next == ST_EXEC) &&
                    ((r_state != ST_EXEC) || core.step_ack);
  end

  // --------------------------------------------------------------------------
  // Datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc       <= '0;
      r_in_img   <= '0;
      r_out_img  <= '0;
      r_scan_cnt <= '0;
      r_prog_len <= '0;
      r_scan_div <= '0;
      r_strobe   <= 1'b0;
    end else if (ena) begin
      r_strobe <= w_strobe_next;
      case (r_state)
        ST_LATCH_IN: begin
          r_in_img   <= in_pins;
          r_pc       <= '0;
          r_prog_len <= prog_len;
          r_scan_div <= scan_div;
        end
        ST_EXEC: begin
          if (core.step_ack && (w_next == ST_EXEC)) r_pc <= r_pc + 8'd1;
        end
        ST_LATCH_OUT: begin
          r_out_img  <= core.core_out;
          r_scan_cnt <= r_scan_cnt + 8'd1;
        end
        default: ;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Counters
  // --------------------------------------------------------------------------
  vslc_step_wdt u_step_wdt (
    .clk      (clk),
    .rst_n    (rst_n),
    .ena      (ena),
    .load     (w_wdt_load),
    .load_val (c_WDT_LOAD),
    .dec      (w_wdt_dec),
    .term     (w_wdt_term)
  );

  vslc_step_wdt u_wait_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .ena      (ena),
    .load     (w_wait_load),
    .load_val (r_scan_div - 8'd1),
    .dec      (w_wait_dec),
    .term     (w_wait_term)
  );

  // --------------------------------------------------------------------------
  // Outputs (decoded from state so reset removes them without a clock edge)
  // --------------------------------------------------------------------------
  assign core.step_req    = (r_state == ST_EXEC);
  assign core.addr_strobe = r_strobe && (r_state == ST_EXEC);
  assign core.pc          = r_pc;
  assign in_img           = r_in_img;
  assign out_img          = r_out_img;
  assign scan_cnt         = r_scan_cnt;
  assign scan_busy        = (r_state != ST_IDLE) && (r_state != ST_FAULT);
  assign fault            = (r_state == ST_FAULT);

endmodule
`default_nettype wire
